// File: rtl/intt_address_generator_if.sv
// Purpose : handshake/bus bundle between the INTT address generator and its RAM/butterfly consumer.
// Latency : none, wires only.
// Backpressure: consumer drives en low to hold the generator; write side is a fixed-latency replay.
// Ports   : start/en flow into the generator; busy, done, rd*, pairSel, stageIdx, twIndex, wr* flow out.
interface intt_address_generator_if #(
    parameter int numStages = 8
);
    localparam int SW = (numStages > 1) ? $clog2(numStages) : 1;
    localparam int TW = (numStages > 1) ? numStages - 1 : 1;

    logic                 start;
    logic                 en;
    logic                 busy;
    logic                 done;
    logic [numStages-1:0] rdAddress;
    logic                 rdValid;
    logic                 pairSel;
    logic [SW-1:0]        stageIdx;
    logic [TW-1:0]        twIndex;
    logic [numStages-1:0] wrAddress;
    logic                 wrValid;

    // Generator side
    modport master (
        input  start, en,
        output busy, done, rdAddress, rdValid, pairSel, stageIdx, twIndex,
               wrAddress, wrValid
    );

    // Consumer / controller side
    modport slave (
        output start, en,
        input  busy, done, rdAddress, rdValid, pairSel, stageIdx, twIndex,
               wrAddress, wrValid
    );
endinterface

// File: rtl/intt_address_generator.sv
// Purpose : inverse-NTT (Gentleman-Sande) address sequencer; stride 1 -> N/2, lo/hi read pairs,
//           twiddle index per butterfly, write address = read address replayed after `delay` cycles.
// Latency : first read the cycle after start is accepted; write side trails reads by exactly `delay`.
// Backpressure: en=0 holds the read position (bubble); the write delay line shifts every cycle.
// Ports   : clk, rst (sync, active-high), bus (intt_address_generator_if.master).
// Option  : define INTT_STAGE_DRAIN_EN to drain the delay line at every stage boundary, so the first
//           read of stage s+1 comes delay+1 cycles after the last read of stage s.
module intt_address_generator #(
    parameter int numStages = 8,
    parameter int delay     = 11
) (
    input  logic                      clk,
    input  logic                      rst,
    intt_address_generator_if.master  bus
);
    localparam int SW = (numStages > 1) ? $clog2(numStages) : 1;
    localparam int TW = (numStages > 1) ? numStages - 1 : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t               state_q;
    logic [SW-1:0]        s_q;
    logic [numStages-1:0] base_q;
    logic [numStages-1:0] j_q;
    logic                 pair_q;
    logic                 pass_end_q;   // last read of the pass has been issued

    logic                 busy_q;
    logic                 done_q;
    logic                 rdValid_q;
    logic [numStages-1:0] rdAddress_q;
    logic                 pairSel_q;
    logic [SW-1:0]        stageIdx_q;
    logic [TW-1:0]        twIndex_q;

    logic [delay-1:0]     dl_vld_q;
    logic [numStages-1:0] dl_adr_q [delay];

    // Current read position; IDLE presents position zero so the start edge can issue directly.
    logic [SW-1:0]        cur_s;
    logic [numStages-1:0] cur_base;
    logic [numStages-1:0] cur_j;
    logic                 cur_pair;

    logic [numStages-1:0] stride;
    logic [numStages-1:0] lo_addr;
    logic [numStages-1:0] hi_addr;
    logic [numStages-1:0] addr_d;
    logic [TW-1:0]        tw_d;
    logic [numStages:0]   base_sum;
    logic [SW-1:0]        s_d;
    logic [numStages-1:0] base_d;
    logic [numStages-1:0] j_d;
    logic                 pair_d;
    logic                 stage_end;
    logic                 last_read;
    logic [delay-1:0]     dl_vld_d;
    logic                 drain_clear;
    logic                 issue_go;

    always_comb begin
        cur_s     = s_q;
        cur_base  = base_q;
        cur_j     = j_q;
        cur_pair  = pair_q;
        if (state_q == IDLE) begin
            cur_s    = '0;
            cur_base = '0;
            cur_j    = '0;
            cur_pair = 1'b0;
        end

        stride   = numStages'(1) << cur_s;
        lo_addr  = cur_base + cur_j;
        hi_addr  = lo_addr + stride;
        addr_d   = cur_pair ? hi_addr : lo_addr;
        tw_d     = TW'(cur_j << (SW'(numStages - 1) - cur_s));
        // Group step of 2^(s+1); the carry-out marks the end of a stage.
        base_sum = {1'b0, cur_base} + {stride, 1'b0};

        s_d       = cur_s;
        base_d    = cur_base;
        j_d       = cur_j;
        pair_d    = ~cur_pair;
        stage_end = 1'b0;
        if (cur_pair) begin
            if (cur_j + numStages'(1) == stride) begin
                j_d    = '0;
                base_d = base_sum[numStages-1:0];
                if (base_sum[numStages]) begin
                    stage_end = 1'b1;
                    s_d       = cur_s + SW'(1);
                end
            end else begin
                j_d = cur_j + numStages'(1);
            end
        end
        last_read = stage_end && (cur_s == SW'(numStages - 1));

        // Delay-line valid bits as they will be after this edge.
        dl_vld_d    = (dl_vld_q << 1) | delay'(rdValid_q);
        drain_clear = ~|dl_vld_d;

        issue_go = bus.en && (((state_q == IDLE) && bus.start) ||
                              (state_q == ISSUE) ||
                              ((state_q == DRAIN) && drain_clear && !pass_end_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= '0;
            base_q      <= '0;
            j_q         <= '0;
            pair_q      <= 1'b0;
            pass_end_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rdValid_q   <= 1'b0;
            rdAddress_q <= '0;
            pairSel_q   <= 1'b0;
            stageIdx_q  <= '0;
            twIndex_q   <= '0;
            dl_vld_q    <= '0;
            for (int k = 0; k < delay; k++) dl_adr_q[k] <= '0;
        end else begin
            dl_vld_q    <= dl_vld_d;
            dl_adr_q[0] <= rdValid_q ? rdAddress_q : '0;
            for (int k = 1; k < delay; k++) dl_adr_q[k] <= dl_adr_q[k-1];

            done_q    <= 1'b0;
            rdValid_q <= issue_go;

            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q    <= ISSUE;
                        busy_q     <= 1'b1;
                        pass_end_q <= 1'b0;
                        s_q        <= '0;
                        base_q     <= '0;
                        j_q        <= '0;
                        pair_q     <= 1'b0;
                    end
                end
                ISSUE: begin
`ifdef INTT_STAGE_DRAIN_EN
                    if (issue_go && stage_end) state_q <= DRAIN;
`else
                    if (issue_go && last_read) state_q <= DRAIN;
`endif
                end
                DRAIN: begin
                    if (drain_clear) begin
                        if (pass_end_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    pass_end_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase

            // Later assignment wins over the start-time counter clear above.
            if (issue_go) begin
                rdAddress_q <= addr_d;
                pairSel_q   <= cur_pair;
                stageIdx_q  <= cur_s;
                twIndex_q   <= tw_d;
                s_q         <= s_d;
                base_q      <= base_d;
                j_q         <= j_d;
                pair_q      <= pair_d;
                pass_end_q  <= last_read;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rdAddress = rdAddress_q;
    assign bus.rdValid   = rdValid_q;
    assign bus.pairSel   = pairSel_q;
    assign bus.stageIdx  = stageIdx_q;
    assign bus.twIndex   = twIndex_q;
    assign bus.wrAddress = dl_adr_q[delay-1];
    assign bus.wrValid   = dl_vld_q[delay-1];
endmodule

// File: tb/tb_intt_address_generator.sv
// Purpose : self-checking bench for intt_address_generator (numStages=3, delay=4).
// Latency : reference model predicts every cycle's outputs; checks sampled 1 time unit after each edge.
// Backpressure: en driven directed and random; model holds its read pointer when en is low.
module tb_intt_address_generator;
    localparam int NS   = 3;
    localparam int DL   = 4;
    localparam int NN   = 1 << NS;
    localparam int TOT  = NS * NN;
    localparam int MAXC = 1024;
`ifdef INTT_STAGE_DRAIN_EN
    localparam bit MACRO = 1'b1;
`else
    localparam bit MACRO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    intt_address_generator_if #(.numStages(NS)) bus();
    intt_address_generator #(.numStages(NS), .delay(DL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Expected read list of one pass, derived straight from the stage/group/butterfly loops.
    int ref_a [TOT];
    int ref_p [TOT];
    int ref_s [TOT];
    int ref_t [TOT];
    bit ref_last [TOT];

    bit hist_v [MAXC];
    int hist_a [MAXC];
    int cyc = 0, rst_cyc = 0, m_idx = 0, m_allowed = 0, m_done = -1;
    bit m_run = 1'b0;
    bit e_v, e_busy, e_done, e_wv;
    int e_a, e_p, e_s, e_t, e_wa;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance one clock with the currently driven inputs, update the model, then compare.
    task automatic tick();
        int n;
        n = cyc + 1;
        e_v = 1'b0; e_a = 0; e_p = 0; e_s = 0; e_t = 0;
        if (rst) begin
            m_run   = 1'b0;
            m_done  = -1;
            rst_cyc = n;
        end else begin
            if (m_run && m_done >= 0 && cyc > m_done) m_run = 1'b0;
            if (!m_run && bus.start) begin
                m_run = 1'b1; m_idx = 0; m_allowed = n; m_done = -1;
            end
            if (m_run && m_idx < TOT && bus.en && n >= m_allowed) begin
                e_v = 1'b1;
                e_a = ref_a[m_idx]; e_p = ref_p[m_idx];
                e_s = ref_s[m_idx]; e_t = ref_t[m_idx];
                if (MACRO && ref_last[m_idx]) m_allowed = n + DL + 1;
                m_idx++;
                if (m_idx == TOT) m_done = n + DL + 1;
            end
        end
        hist_v[n] = e_v;
        hist_a[n] = e_a;
        e_busy = m_run && (m_done < 0 || n < m_done);
        e_done = m_run && (n == m_done);
        if (n - DL >= rst_cyc) begin
            e_wv = hist_v[n-DL];
            e_wa = hist_a[n-DL];
        end else begin
            e_wv = 1'b0;
            e_wa = 0;
        end

        @(posedge clk);
        #1;
        cyc = n;
        chk("rdValid",   32'(bus.rdValid),   32'(e_v));
        chk("busy",      32'(bus.busy),      32'(e_busy));
        chk("done",      32'(bus.done),      32'(e_done));
        chk("wrValid",   32'(bus.wrValid),   32'(e_wv));
        chk("wrAddress", 32'(bus.wrAddress), e_wa);
        if (e_v) begin
            chk("rdAddress", 32'(bus.rdAddress), e_a);
            chk("pairSel",   32'(bus.pairSel),   e_p);
            chk("stageIdx",  32'(bus.stageIdx),  e_s);
            chk("twIndex",   32'(bus.twIndex),   e_t);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdAddress"}, 32'(bus.rdAddress), 0);
        chk({tag, "_pairSel"},   32'(bus.pairSel),   0);
        chk({tag, "_stageIdx"},  32'(bus.stageIdx),  0);
        chk({tag, "_twIndex"},   32'(bus.twIndex),   0);
        chk({tag, "_wrAddress"}, 32'(bus.wrAddress), 0);
    endtask

    int plan [TOT] = '{0,1,2,3,4,5,6,7, 0,2,1,3,4,6,5,7, 0,4,1,5,2,6,3,7};
    int rdq [$];
    int rdcyc [$];
    int c0, rel, done_rel, saw, s1;

    initial begin
        // Build the reference read list.
        begin
            int k;
            k = 0;
            for (int s = 0; s < NS; s++) begin
                for (int base = 0; base < NN; base += (2 << s)) begin
                    for (int j = 0; j < (1 << s); j++) begin
                        for (int p = 0; p < 2; p++) begin
                            ref_a[k]    = (base + j + p * (1 << s)) % NN;
                            ref_p[k]    = p;
                            ref_s[k]    = s;
                            ref_t[k]    = j << (NS - 1 - s);
                            ref_last[k] = (p == 1) && (j == (1 << s) - 1) && (base + (2 << s) == NN);
                            k++;
                        end
                    end
                end
            end
        end

        // Reset with start asserted: reset must win.
        rst = 1'b1; bus.start = 1'b1; bus.en = 1'b1;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0; bus.start = 1'b0;
        repeat (2) tick();

        // Pass 1: en=1 throughout, stray start at cycle 6 must be ignored.
        bus.start = 1'b1; bus.en = 1'b1; c0 = cyc;
        tick();
        done_rel = -1;
        for (int r = 1; r <= 45; r++) begin
            rel = cyc - c0;
            if (bus.rdValid) begin
                rdq.push_back(int'(bus.rdAddress));
                rdcyc.push_back(rel);
            end
            if (bus.done) done_rel = rel;
            bus.start = (rel == 6);
            tick();
        end
        bus.start = 1'b0;
        chk("p1_nreads", rdq.size(), TOT);
        for (int i = 0; i < TOT && i < rdq.size(); i++) chk("p1_seq", rdq[i], plan[i]);
        if (rdcyc.size() == TOT) begin
            chk("p1_first_rd",  rdcyc[0],  1);
            chk("p1_stage1_rd", rdcyc[8],  MACRO ? 13 : 9);
            chk("p1_stage2_rd", rdcyc[16], MACRO ? 25 : 17);
            chk("p1_last_rd",   rdcyc[TOT-1], MACRO ? 32 : 24);
        end
        chk("p1_done_cycle", done_rel, MACRO ? 37 : 29);

        // Pass 2: en toggles 1,0,1,0,... over stage 1, random afterwards.
        bus.start = 1'b1; bus.en = 1'b1; c0 = cyc;
        tick();
        bus.start = 1'b0;
        saw = 0;
        s1 = MACRO ? 13 : 9;
        for (int r = 0; r < 200; r++) begin
            rel = cyc - c0;
            if (rel < s1 - 1)      bus.en = 1'b1;
            else if (rel < s1 + 7) bus.en = ((rel - s1 + 1) % 2 == 0);
            else                   bus.en = ($urandom_range(0, 3) != 0);
            tick();
            if (bus.done) saw++;
        end
        chk("p2_done_once", saw, 1);

        // Pass 3: random en, reset (with start) at cycle 10, idle, then restart.
        bus.start = 1'b1; bus.en = 1'b1; c0 = cyc;
        tick();
        bus.start = 1'b0;
        for (int r = 0; r < 9; r++) begin
            bus.en = ($urandom_range(0, 1) != 0);
            tick();
        end
        rst = 1'b1; bus.start = 1'b1;
        tick();
        rst = 1'b0; bus.start = 1'b0;
        chk_all_zero("midreset");
        for (int r = 0; r < 20; r++) begin
            bus.en = ($urandom_range(0, 1) != 0);
            tick();
        end
        bus.start = 1'b1; bus.en = 1'b1;
        tick();
        bus.start = 1'b0;
        saw = 0;
        for (int r = 0; r < 45; r++) begin
            tick();
            if (bus.done) saw++;
        end
        chk("p3_done_once", saw, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
